// File: rtl/pwm_pkg.sv
// Shared definitions for PWM-side controllers: default duty width, ramp FSM
// states and the saturating step used to slew a duty word toward a target.
package pwm_pkg;

  localparam int unsigned DefaultDutyWidth = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRamp
  } ramp_state_e;

  // Move cur toward tgt by at most step. Works on signed ints so the difference
  // can be negative and the result never wraps outside the 0..tgt span.
  function automatic int step_toward(input int cur, input int tgt, input int step);
    int diff;
    diff = tgt - cur;
    if (diff > step) begin
      return cur + step;
    end
    if (diff < -step) begin
      return cur - step;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter. period_tick marks the last clock of each
// 2^DUTY_WIDTH-clock period, lining up with the PWM counter restart.
module pwm_period_timer #(
  parameter int unsigned DUTY_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  logic [DUTY_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: natural wrap at 2^DUTY_WIDTH-1.
  always_comb begin
    cnt_d = cnt_q + DUTY_WIDTH'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign period_tick = (cnt_q == '1);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Rate-limited duty controller: accepts targets over valid/ready and slews
// duty_out toward the effective target by at most STEP counts, updating only
// on PWM period boundaries. Dropping enable ramps the output down to 0.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_WIDTH       = DefaultDutyWidth,
  parameter int unsigned STEP             = 4,
  parameter int unsigned PERIODS_PER_STEP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DUTY_WIDTH-1:0] tgt_duty,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  output logic [DUTY_WIDTH-1:0] duty_out,
  output logic                  period_tick,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned DivWidth = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [DivWidth-1:0] DivLast = DivWidth'(PERIODS_PER_STEP - 1);

  ramp_state_e           state_q, state_d;
  logic [DivWidth-1:0]   step_div_q, step_div_d;
  logic [DUTY_WIDTH-1:0] target_q, target_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DUTY_WIDTH-1:0] eff;
  logic [DUTY_WIDTH-1:0] duty_step;

  pwm_period_timer #(
    .DUTY_WIDTH(DUTY_WIDTH)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .period_tick(period_tick)
  );

  assign tgt_ready = enable & ~rst;
  assign eff       = enable ? target_q : '0;
  assign duty_step = DUTY_WIDTH'(step_toward(int'(duty_q), int'(eff), int'(STEP)));

  // Target capture, ramp FSM next-state and duty update.
  always_comb begin
    target_d   = target_q;
    state_d    = state_q;
    step_div_d = step_div_q;
    duty_d     = duty_q;
    done_d     = 1'b0;

    if (tgt_valid && tgt_ready) begin
      target_d = tgt_duty;
    end

    unique case (state_q)
      StIdle: begin
        step_div_d = '0;
        if (eff != duty_q) begin
          state_d = StRamp;
        end
      end
      StRamp: begin
        if (eff == duty_q) begin
          // Retargeted onto the current output: finish without touching duty.
          state_d    = StIdle;
          step_div_d = '0;
          done_d     = 1'b1;
        end else if (period_tick) begin
          if (step_div_q == DivLast) begin
            step_div_d = '0;
            duty_d     = duty_step;
            if (duty_step == eff) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            step_div_d = step_div_q + DivWidth'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StRamp);
  end

  // State registers with synchronous reset; reset drops duty straight to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      step_div_q <= '0;
      target_q   <= '0;
      duty_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_div_q <= step_div_d;
      target_q   <= target_d;
      duty_q     <= duty_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with DUTY_WIDTH=8, STEP=4,
// PERIODS_PER_STEP=2. Time t counts clocks since reset release and equals the
// period counter value modulo 256.
module tb_pwm_duty_ramp_ctrl;

  localparam int UpdInt = 512;  // clocks between updates
  localparam int Step   = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] tgt_duty;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] duty_out;
  logic       period_tick;
  logic       busy;
  logic       done;

  int t;
  int n_checks;
  int n_errs;

  pwm_duty_ramp_ctrl #(
    .DUTY_WIDTH      (8),
    .STEP            (4),
    .PERIODS_PER_STEP(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .tgt_duty   (tgt_duty),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .duty_out   (duty_out),
    .period_tick(period_tick),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
    end
  endtask

  // One-cycle reset; on return the DUT has just been reset and t=0.
  task automatic do_reset();
    rst       = 1'b1;
    tgt_valid = 1'b0;
    enable    = 1'b1;
    #1;
    check_eq("ready low in reset", 32'(tgt_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    t   = 0;
  endtask

  task automatic send(input int v);
    tgt_duty  = 8'(v);
    tgt_valid = 1'b1;
    check_eq($sformatf("ready for tgt %0d", v), 32'(tgt_ready), 1);
    adv(1);
    tgt_valid = 1'b0;
  endtask

  // Expected duty: starts at from_v, first update visible at base_t+512, then
  // one Step every 512 clocks, clamped at to_v.
  task automatic track(input string tag, input int t_end, input int base_t, input int from_v,
                       input int to_v, output int dones, output int done_t);
    int  k;
    int  e;
    bit  bad;
    dones  = 0;
    done_t = -1;
    bad    = 1'b0;
    e      = from_v;
    while (t < t_end) begin
      adv(1);
      k = (t - base_t) / UpdInt;
      if (to_v >= from_v) begin
        e = from_v + Step * k;
        if (e > to_v) e = to_v;
      end else begin
        e = from_v - Step * k;
        if (e < to_v) e = to_v;
      end
      if (!bad && 32'(duty_out) != e) begin
        bad = 1'b1;
        check_eq($sformatf("%s duty t=%0d", tag, t), 32'(duty_out), e);
      end
      if (done) begin
        dones++;
        if (done_t < 0) done_t = t;
      end
    end
    check_eq({tag, " final duty"}, 32'(duty_out), e);
  endtask

  initial begin
    int nt, t1, t2, dn, bz, nz;
    int d, dt;
    n_checks  = 0;
    n_errs    = 0;
    t         = 0;
    tgt_duty  = '0;
    tgt_valid = 1'b0;
    enable    = 1'b1;
    rst       = 1'b1;

    // Reset values and idle period ticks.
    do_reset();
    check_eq("rst duty", 32'(duty_out), 0);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst done", 32'(done), 0);
    check_eq("rst tick", 32'(period_tick), 0);
    nt = 0; t1 = -1; t2 = -1; dn = 0; bz = 0; nz = 0;
    while (t < 600) begin
      adv(1);
      if (period_tick) begin
        nt++;
        if (t1 < 0) t1 = t;
        else if (t2 < 0) t2 = t;
      end
      if (done) dn++;
      if (busy) bz++;
      if (duty_out != 0) nz++;
    end
    check_eq("idle tick count", nt, 2);
    check_eq("idle tick 1", t1, 255);
    check_eq("idle tick 2", t2, 511);
    check_eq("idle done cycles", dn, 0);
    check_eq("idle busy cycles", bz, 0);
    check_eq("idle duty nonzero", nz, 0);

    // Ramp 0 -> 16 from a transfer at cnt=10.
    do_reset();
    adv(10);
    send(16);
    check_eq("s2 busy t11", 32'(busy), 0);
    adv(1);
    check_eq("s2 busy t12", 32'(busy), 1);
    track("s2", 2100, 0, 0, 16, d, dt);
    check_eq("s2 done pulses", d, 1);
    check_eq("s2 done time", dt, 2048);
    check_eq("s2 busy after", 32'(busy), 0);

    // Clamp at the top: 252 -> 255 in one update.
    do_reset();
    adv(10);
    send(255);
    track("s3 up", 32800, 0, 0, 255, d, dt);
    check_eq("s3 up done pulses", d, 1);
    check_eq("s3 up done time", dt, 32768);

    // Clamp at the bottom: 3 -> 0 in one update.
    do_reset();
    adv(10);
    send(3);
    track("s3 to3", 700, 0, 0, 3, d, dt);
    check_eq("s3 to3 done time", dt, 512);
    send(0);
    track("s3 down", 1100, 512, 3, 0, d, dt);
    check_eq("s3 down done pulses", d, 1);
    check_eq("s3 down done time", dt, 1024);

    // Retarget 40 -> 8 at duty 20, then a transfer on an update edge.
    do_reset();
    adv(10);
    send(40);
    track("s4 up", 2600, 0, 0, 40, d, dt);
    check_eq("s4 up no done", d, 0);
    send(8);
    track("s4 retarget", 4200, 2560, 20, 8, d, dt);
    check_eq("s4 retarget done pulses", d, 1);
    check_eq("s4 retarget done time", dt, 4096);
    send(20);
    track("s4 up2", 4607, 4096, 8, 20, d, dt);
    send(10);  // lands on the 8 -> 12 update edge
    check_eq("s4 same-edge uses old tgt", 32'(duty_out), 12);
    track("s4 settle", 5200, 4608, 12, 10, d, dt);
    check_eq("s4 settle done time", dt, 5120);

    // Soft stop 40 -> 0, ignored transfer while disabled, ramp back to 40.
    do_reset();
    adv(10);
    send(40);
    track("s5 up", 5200, 0, 0, 40, d, dt);
    check_eq("s5 up done time", dt, 5120);
    enable = 1'b0;
    #1;
    check_eq("s5 ready low", 32'(tgt_ready), 0);
    track("s5 down a", 6000, 5120, 40, 0, d, dt);
    tgt_duty  = 8'd99;
    tgt_valid = 1'b1;
    adv(1);
    tgt_valid = 1'b0;
    track("s5 down b", 10300, 5120, 40, 0, d, dt);
    check_eq("s5 down done time", dt, 10240);
    enable = 1'b1;
    #1;
    check_eq("s5 ready high", 32'(tgt_ready), 1);
    track("s5 back", 15400, 10240, 0, 40, d, dt);
    check_eq("s5 back done time", dt, 15360);
    check_eq("s5 back done pulses", d, 1);

    // Reset mid-ramp at duty 24.
    do_reset();
    adv(10);
    send(40);
    track("s6 up", 3100, 0, 0, 40, d, dt);
    check_eq("s6 pre-reset busy", 32'(busy), 1);
    do_reset();
    check_eq("s6 duty after rst", 32'(duty_out), 0);
    check_eq("s6 busy after rst", 32'(busy), 0);
    check_eq("s6 done after rst", 32'(done), 0);
    adv(254);
    check_eq("s6 tick t254", 32'(period_tick), 0);
    adv(1);
    check_eq("s6 tick t255", 32'(period_tick), 1);
    track("s6 idle", 600, 0, 0, 0, d, dt);
    check_eq("s6 idle done pulses", d, 0);
    check_eq("s6 idle busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
